// File: rtl/modexp_ctrl_fsm.sv
// Right-to-left modexp sequencer: PRE op, one LOOP op per exponent bit, POST op, one-cycle eoc.
// Latency 1+MMM_CYCLES*(N+2) cycles from start; en=0 freezes every flop, so ops stretch by the stall.
module modexp_ctrl_fsm #(
  parameter int EXP_WIDTH  = 16,
  parameter int MMM_CYCLES = 12,
  parameter bit SKIP_LZ    = 1'b0,
  parameter int IDX_W      = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 rst_mmm,
  output logic                 ld_a,
  output logic                 ld_r,
  output logic                 lock1,
  output logic                 lock2,
  output logic [1:0]           sel1,
  output logic                 sel2,
  output logic                 busy,
  output logic                 eoc,
  output logic [IDX_W-1:0]     bit_idx
);

  localparam int              PH_W    = $clog2(MMM_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(MMM_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRE, LOOP, POST, DONE} state_t;

  state_t               state, state_nxt;
  logic [PH_W-1:0]      phase, phase_nxt;
  logic [EXP_WIDTH-1:0] exp_reg, exp_nxt, exp_shift;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 op_last;

  logic       rst_mmm_nxt, ld_a_nxt, ld_r_nxt, lock1_nxt, lock2_nxt;
  logic [1:0] sel1_nxt;
  logic       sel2_nxt, busy_nxt, eoc_nxt;

  assign op_last   = (phase == PH_LAST);
  assign exp_shift = {1'b0, exp_reg[EXP_WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    exp_nxt   = exp_reg;
    idx_nxt   = bit_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PRE;
          phase_nxt = '0;
          exp_nxt   = exp;
          idx_nxt   = '0;
        end
      end
      PRE: begin
        if (op_last) begin
          phase_nxt = '0;
          state_nxt = (SKIP_LZ && (exp_reg == '0)) ? POST : LOOP;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      LOOP: begin
        if (op_last) begin
          phase_nxt = '0;
          exp_nxt   = exp_shift;
          idx_nxt   = bit_idx + 1'b1;
          if ((idx_nxt == IDX_W'(EXP_WIDTH)) || (SKIP_LZ && (exp_shift == '0)))
            state_nxt = POST;
          else
            state_nxt = LOOP;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      POST: begin
        if (op_last) begin
          phase_nxt = '0;
          state_nxt = DONE;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      DONE: begin
        // bit_idx stays visible during eoc, then clears so IDLE shows all zeros
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the register bank as flop outputs
    rst_mmm_nxt = 1'b0;
    ld_a_nxt    = 1'b0;
    ld_r_nxt    = 1'b0;
    lock1_nxt   = 1'b0;
    lock2_nxt   = 1'b0;
    sel1_nxt    = 2'b00;
    sel2_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    eoc_nxt     = 1'b0;
    if (state_nxt == PRE || state_nxt == LOOP || state_nxt == POST) begin
      rst_mmm_nxt = 1'b1;
      busy_nxt    = 1'b1;
      ld_a_nxt    = (phase_nxt == '0);
      ld_r_nxt    = (phase_nxt == PH_LAST);
    end
    case (state_nxt)
      PRE: begin
        lock1_nxt = 1'b1;
        lock2_nxt = 1'b1;
      end
      LOOP: begin
        sel1_nxt  = 2'b01;
        sel2_nxt  = 1'b1;
        lock2_nxt = 1'b1;
        lock1_nxt = exp_nxt[0];
      end
      POST: begin
        sel1_nxt  = 2'b10;
        sel2_nxt  = 1'b1;
        lock1_nxt = 1'b1;
      end
      DONE: begin
        rst_mmm_nxt = 1'b1;
        sel1_nxt    = 2'b10;
        sel2_nxt    = 1'b1;
        lock1_nxt   = 1'b1;
        eoc_nxt     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      exp_reg <= '0;
      bit_idx <= '0;
      rst_mmm <= 1'b0;
      ld_a    <= 1'b0;
      ld_r    <= 1'b0;
      lock1   <= 1'b0;
      lock2   <= 1'b0;
      sel1    <= 2'b00;
      sel2    <= 1'b0;
      busy    <= 1'b0;
      eoc     <= 1'b0;
    end else if (en) begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      exp_reg <= exp_nxt;
      bit_idx <= idx_nxt;
      rst_mmm <= rst_mmm_nxt;
      ld_a    <= ld_a_nxt;
      ld_r    <= ld_r_nxt;
      lock1   <= lock1_nxt;
      lock2   <= lock2_nxt;
      sel1    <= sel1_nxt;
      sel2    <= sel2_nxt;
      busy    <= busy_nxt;
      eoc     <= eoc_nxt;
    end
  end

endmodule

// File: tb/tb_modexp_ctrl_fsm.sv
// Bench for modexp_ctrl_fsm: two instances (SKIP_LZ=0 and 1), directed runs, scoreboard checked on eoc.
`timescale 1ns/1ps
module tb_modexp_ctrl_fsm;

  localparam int MC = 12;

  typedef struct packed {
    logic       rst_mmm, ld_a, ld_r, lock1, lock2;
    logic [1:0] sel1;
    logic       sel2, busy, eoc;
    logic [3:0] bit_idx;
  } obs_t;

  typedef struct {
    int         t_acc;
    int         eoc_cyc;
    int         n;
    int         busy;
    int         loop;
    logic [7:0] seq;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       start0, start1;
  logic [7:0] exp0, exp1;
  logic       rst_mmm0, ld_a0, ld_r0, lock10, lock20, sel20, busy0, eoc0;
  logic       rst_mmm1, ld_a1, ld_r1, lock11, lock21, sel21, busy1, eoc1;
  logic [1:0] sel10, sel11;
  logic [3:0] bit_idx0, bit_idx1;

  obs_t ob [2];
  assign ob[0] = {rst_mmm0, ld_a0, ld_r0, lock10, lock20, sel10, sel20, busy0, eoc0, bit_idx0};
  assign ob[1] = {rst_mmm1, ld_a1, ld_r1, lock11, lock21, sel11, sel21, busy1, eoc1, bit_idx1};

  modexp_ctrl_fsm #(.EXP_WIDTH(8), .MMM_CYCLES(MC), .SKIP_LZ(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .start(start0), .exp(exp0),
    .rst_mmm(rst_mmm0), .ld_a(ld_a0), .ld_r(ld_r0), .lock1(lock10), .lock2(lock20),
    .sel1(sel10), .sel2(sel20), .busy(busy0), .eoc(eoc0), .bit_idx(bit_idx0)
  );

  modexp_ctrl_fsm #(.EXP_WIDTH(8), .MMM_CYCLES(MC), .SKIP_LZ(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .start(start1), .exp(exp1),
    .rst_mmm(rst_mmm1), .ld_a(ld_a1), .ld_r(ld_r1), .lock1(lock11), .lock2(lock21),
    .sel1(sel11), .sel2(sel21), .busy(busy1), .eoc(eoc1), .bit_idx(bit_idx1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  rec_t sb0[$];
  rec_t sb1[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  task automatic push(input int inst, input int t, input int n, input logic [7:0] seq, input int stall);
    rec_t r;
    r.t_acc   = t;
    r.n       = n;
    r.seq     = seq;
    r.busy    = MC * (n + 2) + stall;
    r.loop    = MC * n + stall;
    r.eoc_cyc = t + MC * (n + 2) + stall;
    if (inst == 0) sb0.push_back(r);
    else           sb1.push_back(r);
  endtask

  task automatic to_cyc(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  // Issue start pulses; t returns the edge count of the accepting edge
  task automatic go(input bit s0, input logic [7:0] e0, input bit s1, input logic [7:0] e1, output int t);
    start0 = s0; exp0 = e0;
    start1 = s1; exp1 = e1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    t = cyc;
  endtask

  // Monitor: accumulate per-run observations, compare against the scoreboard on eoc
  bit         in_run [2];
  int         busy_n [2], lda_n [2], ldr_n [2], loop_n [2], ops_n [2], first_cyc [2];
  logic [7:0] seq_m  [2];
  rec_t       r_m;
  bit         have_m;
  obs_t       ex_m;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_run[i] = 1'b0;
      end else begin
        if (ob[i].busy && !in_run[i]) begin
          in_run[i]    = 1'b1;
          busy_n[i]    = 0;
          lda_n[i]     = 0;
          ldr_n[i]     = 0;
          loop_n[i]    = 0;
          ops_n[i]     = 0;
          seq_m[i]     = 8'h00;
          first_cyc[i] = cyc;
        end
        if (in_run[i]) begin
          if (ob[i].busy) busy_n[i]++;
          if (ob[i].ld_a) lda_n[i]++;
          if (ob[i].ld_r) ldr_n[i]++;
          if (ob[i].sel1 == 2'b01) loop_n[i]++;
          if (ob[i].sel1 == 2'b01 && ob[i].ld_a) begin
            if (ops_n[i] < 8) seq_m[i][ops_n[i]] = ob[i].lock1;
            ops_n[i]++;
          end
        end
        if (ob[i].eoc) begin
          have_m = 1'b0;
          if (i == 0 && sb0.size() > 0) begin
            r_m = sb0.pop_front(); have_m = 1'b1;
          end else if (i == 1 && sb1.size() > 0) begin
            r_m = sb1.pop_front(); have_m = 1'b1;
          end
          if (!have_m) begin
            checks++;
            errors++;
            $display("FAIL unexpected_eoc: instance %0d raised eoc at cycle %0d with no run expected", i, cyc);
          end else begin
            ex_m = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 4'(r_m.n)};
            chk($sformatf("u%0d_eoc_cycle", i),   cyc,                r_m.eoc_cyc);
            chk($sformatf("u%0d_first_ld_a", i),  first_cyc[i],       r_m.t_acc);
            chk($sformatf("u%0d_busy_cycles", i), busy_n[i],          r_m.busy);
            chk($sformatf("u%0d_loop_ops", i),    ops_n[i],           r_m.n);
            chk($sformatf("u%0d_loop_cycles", i), loop_n[i],          r_m.loop);
            chk($sformatf("u%0d_lock1_seq", i),   int'(seq_m[i]),     int'(r_m.seq));
            chk($sformatf("u%0d_ld_a_count", i),  lda_n[i],           r_m.n + 2);
            chk($sformatf("u%0d_ld_r_count", i),  ldr_n[i],           r_m.n + 2);
            chk($sformatf("u%0d_done_outputs", i), int'(ob[i]),       int'(ex_m));
          end
          in_run[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int         t, t1, t2, c0;
  logic [7:0] e1v, e2v;
  obs_t       frz;

  initial begin
    rst = 1'b1; en = 1'b1;
    start0 = 1'b0; start1 = 1'b0; exp0 = 8'h00; exp1 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_u0", int'(ob[0]), 0);
    chk("reset_outputs_u1", int'(ob[1]), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs_u0", int'(ob[0]), 0);
    chk("idle_outputs_u1", int'(ob[1]), 0);
    @(posedge clk); #1;

    // B5 full width on u0; 03 terminates after 2 ops on u1
    go(1'b1, 8'hB5, 1'b1, 8'h03, t);
    push(0, t, 8, 8'hB5, 0);
    push(1, t, 2, 8'h03, 0);
    to_cyc(t + 125);

    // zero exponent: 8 ops of lock1=0 vs direct PRE->POST
    go(1'b1, 8'h00, 1'b1, 8'h00, t);
    push(0, t, 8, 8'h00, 0);
    push(1, t, 0, 8'h00, 0);
    to_cyc(t + 125);

    // 5-cycle stall at phase 5 of the third loop op
    go(1'b1, 8'hB5, 1'b0, 8'h00, t);
    push(0, t, 8, 8'hB5, 5);
    to_cyc(t + 41);
    en  = 1'b0;
    frz = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 4'd2};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_frozen_%0d", k), int'(ob[0]), int'(frz));
      @(posedge clk); #1;
    end
    en = 1'b1;
    to_cyc(t + 130);

    // asynchronous reset in the fourth loop op, then fresh runs
    go(1'b1, 8'hB5, 1'b0, 8'h00, t);
    to_cyc(t + 51);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_u0", int'(ob[0]), 0);
    chk("async_reset_busy_u0", int'(busy0), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    go(1'b1, 8'h01, 1'b1, 8'h80, t);
    push(0, t, 8, 8'h01, 0);
    push(1, t, 8, 8'h80, 0);
    to_cyc(t + 125);

    // start held high with exp changing every cycle: only accepting edges capture
    c0  = cyc;
    t1  = c0 + 1;
    e1v = 8'(c0) ^ 8'h5A;
    t2  = t1 + MC * 10 + 2;
    e2v = 8'(t2 - 1) ^ 8'h5A;
    push(0, t1, 8, e1v, 0);
    push(0, t2, 8, e2v, 0);
    start0 = 1'b1;
    while (cyc < t2) begin
      exp0 = 8'(cyc) ^ 8'h5A;
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    to_cyc(t2 + 125);

    chk("scoreboard_drained_u0", sb0.size(), 0);
    chk("scoreboard_drained_u1", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
